// File: rtl/spi_apb_pkg.sv
// Shared definitions for the SPI controller APB arbitration path.
package spi_apb_pkg;

    localparam int APB_AW = 32;
    localparam int APB_DW = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_t;

endpackage

// File: rtl/spi_apb_arbiter_rr_pick.sv
// Combinational round-robin picker: first request strictly after i_last, wrapping.
module rr_pick #(
    parameter  int N  = 2,
    localparam int LW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [LW-1:0] i_last,
    output logic [N-1:0]  o_grant,
    output logic [LW-1:0] o_idx,
    output logic          o_valid
);

    always_comb begin : pick
        int unsigned j;
        o_grant = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        j       = 0;
        for (int unsigned k = 1; k <= N; k++) begin
            j = (32'(i_last) + k) % N;
            if (!o_valid && i_req[LW'(j)]) begin
                o_valid          = 1'b1;
                o_grant[LW'(j)]  = 1'b1;
                o_idx            = LW'(j);
            end
        end
    end

endmodule

// File: rtl/spi_apb_arbiter.sv
// N-to-1 APB arbiter in front of the SPI/XIP controller slave port.
// Round-robin selection, latched request fields, one idle cycle between transfers.
module spi_apb_arbiter
    import spi_apb_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [APB_AW*NREQ-1:0] req_paddr,
    input  logic [NREQ-1:0]        req_psel,
    input  logic [NREQ-1:0]        req_penable,
    input  logic [NREQ-1:0]        req_pwrite,
    input  logic [APB_DW*NREQ-1:0] req_pwdata,
    input  logic [4*NREQ-1:0]      req_pstrb,
    input  logic [3*NREQ-1:0]      req_pprot,
    output logic [NREQ-1:0]        req_pready,
    output logic [NREQ-1:0]        req_pslverr,
    output logic [APB_DW-1:0]      req_prdata,
    output logic [APB_AW-1:0]      out_paddr,
    output logic [APB_DW-1:0]      out_pwdata,
    output logic                   out_psel,
    output logic                   out_penable,
    output logic                   out_pwrite,
    output logic [3:0]             out_pstrb,
    output logic [2:0]             out_pprot,
    input  logic                   out_pready,
    input  logic                   out_pslverr,
    input  logic [APB_DW-1:0]      out_prdata,
    output logic [NREQ-1:0]        grant_o
);

    localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;

    apb_state_t        r_state, w_next;
    logic [LW-1:0]     r_last;
    logic [NREQ-1:0]   r_grant;
    logic [APB_AW-1:0] r_paddr;
    logic [APB_DW-1:0] r_pwdata;
    logic              r_pwrite;
    logic [3:0]        r_pstrb;
    logic [2:0]        r_pprot;

    logic [NREQ-1:0]   w_onehot;
    logic [LW-1:0]     w_idx;
    logic              w_valid;
    logic              w_done;
    logic              w_unused_penable;

    // The arbiter generates its own phase sequencing, so requester penable is not needed.
    assign w_unused_penable = ^req_penable;

    rr_pick #(
        .N (NREQ)
    ) u_rr_pick (
        .i_req   (req_psel),
        .i_last  (r_last),
        .o_grant (w_onehot),
        .o_idx   (w_idx),
        .o_valid (w_valid)
    );

    assign w_done = (r_state == ST_ACCESS) && out_pready;

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_valid) w_next = ST_SETUP;
            ST_SETUP:  w_next = ST_ACCESS;
            ST_ACCESS: if (out_pready) w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_last   <= LW'(NREQ - 1);
            r_grant  <= '0;
            r_paddr  <= '0;
            r_pwdata <= '0;
            r_pwrite <= 1'b0;
            r_pstrb  <= '0;
            r_pprot  <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_IDLE && w_valid) begin
                r_grant  <= w_onehot;
                r_last   <= w_idx;
                r_paddr  <= req_paddr[int'(w_idx)*APB_AW +: APB_AW];
                r_pwdata <= req_pwdata[int'(w_idx)*APB_DW +: APB_DW];
                r_pwrite <= req_pwrite[w_idx];
                r_pstrb  <= req_pstrb[int'(w_idx)*4 +: 4];
                r_pprot  <= req_pprot[int'(w_idx)*3 +: 3];
            end else if (w_done) begin
                r_grant <= '0;
            end
        end
    end

    assign out_psel    = (r_state != ST_IDLE);
    assign out_penable = (r_state == ST_ACCESS);
    assign out_paddr   = r_paddr;
    assign out_pwdata  = r_pwdata;
    assign out_pwrite  = r_pwrite;
    assign out_pstrb   = r_pstrb;
    assign out_pprot   = r_pprot;
    assign grant_o     = r_grant;
    assign req_pready  = r_grant & {NREQ{w_done}};
    assign req_pslverr = r_grant & {NREQ{w_done & out_pslverr}};
    assign req_prdata  = out_prdata;

endmodule

// File: tb/tb_spi_apb_arbiter.sv
// Randomized scenario bench for spi_apb_arbiter with a round-robin reference model.
module tb_spi_apb_arbiter;

    localparam int N = 2;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic [32*N-1:0] req_paddr, req_pwdata;
    logic [N-1:0]    req_psel, req_penable, req_pwrite;
    logic [4*N-1:0]  req_pstrb;
    logic [3*N-1:0]  req_pprot;
    logic [N-1:0]    req_pready, req_pslverr, grant_o;
    logic [31:0]     req_prdata, out_paddr, out_pwdata, out_prdata;
    logic            out_psel, out_penable, out_pwrite, out_pready, out_pslverr;
    logic [3:0]      out_pstrb;
    logic [2:0]      out_pprot;

    int total = 0;
    int bad   = 0;
    int m_last;

    logic [31:0] f_addr[N];
    logic [31:0] f_wd[N];
    logic        f_wr[N];
    logic [3:0]  f_strb[N];
    logic [2:0]  f_prot[N];

    typedef struct {
        bit          ok;
        int          cycles;
        bit          early;
        logic [N-1:0] grant, ready, err;
        logic [31:0] rdata, addr, wd;
        logic        wr;
        logic [3:0]  strb;
        logic [2:0]  prot;
    } cap_t;

    spi_apb_arbiter #(.NREQ(N)) dut (
        .clock(clock), .reset(reset),
        .req_paddr(req_paddr), .req_psel(req_psel), .req_penable(req_penable),
        .req_pwrite(req_pwrite), .req_pwdata(req_pwdata), .req_pstrb(req_pstrb),
        .req_pprot(req_pprot), .req_pready(req_pready), .req_pslverr(req_pslverr),
        .req_prdata(req_prdata), .out_paddr(out_paddr), .out_pwdata(out_pwdata),
        .out_psel(out_psel), .out_penable(out_penable), .out_pwrite(out_pwrite),
        .out_pstrb(out_pstrb), .out_pprot(out_pprot), .out_pready(out_pready),
        .out_pslverr(out_pslverr), .out_prdata(out_prdata), .grant_o(grant_o)
    );

    always #5 clock = ~clock;

    // Reference arbitration: first requester after the previous winner, wrapping.
    function automatic int rr_ref(input logic [N-1:0] r, input int last);
        for (int k = 1; k <= N; k++)
            if (r[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    function automatic logic [N-1:0] oh(input int w);
        logic [N-1:0] v;
        v = '0;
        if (w >= 0) v[w] = 1'b1;
        return v;
    endfunction

    task automatic tick;
        @(posedge clock);
        #2;
    endtask

    task automatic set_req(input int i, input logic sel, input logic [31:0] a, input logic wr,
                           input logic [31:0] wd, input logic [3:0] st, input logic [2:0] pr);
        req_psel[i]           = sel;
        req_penable[i]        = 1'($urandom_range(0, 1));
        req_paddr[32*i +: 32]  = a;
        req_pwrite[i]         = wr;
        req_pwdata[32*i +: 32] = wd;
        req_pstrb[4*i +: 4]   = st;
        req_pprot[3*i +: 3]   = pr;
        f_addr[i] = a; f_wr[i] = wr; f_wd[i] = wd; f_strb[i] = st; f_prot[i] = pr;
    endtask

    task automatic rand_req(input int i, input logic sel);
        set_req(i, sel, $urandom, 1'($urandom_range(0, 1)), $urandom,
                4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)));
    endtask

    // Plays the SPI controller: waits for ACCESS, stretches it, then completes.
    task automatic complete(input int waits, input logic [31:0] rd, input logic err, output cap_t c);
        c = '{default: 0};
        for (int n = 0; n < 20; n++) begin
            #1;
            if (out_psel && out_penable) begin
                c.ok = 1'b1;
                break;
            end
            tick;
            c.cycles++;
        end
        if (!c.ok) return;
        c.grant = grant_o; c.addr = out_paddr; c.wr = out_pwrite;
        c.wd = out_pwdata; c.strb = out_pstrb; c.prot = out_pprot;
        for (int w = 0; w < waits; w++) begin
            if (req_pready != '0 || req_pslverr != '0 || !(out_psel && out_penable)) c.early = 1'b1;
            tick;
            #1;
        end
        out_pready = 1'b1; out_prdata = rd; out_pslverr = err;
        #1;
        c.ready = req_pready; c.err = req_pslverr; c.rdata = req_prdata;
        tick;
        out_pready = 1'b0; out_pslverr = 1'b0; out_prdata = $urandom;
    endtask

    task automatic test_reset;
        cap_t c;
        #1 reset = 1'b0;
        tick;
        #1;
        total++;
        if ({out_psel, out_penable, out_pwrite, out_paddr, out_pwdata, out_pstrb, out_pprot,
             req_pready, req_pslverr, grant_o} !== '0) begin
            bad++; $display("FAIL reset_vals got psel=%b grant=%b paddr=%h", out_psel, grant_o, out_paddr);
        end
        tick;
        reset = 1'b1;
        set_req(0, 1'b1, 32'h3000_0100, 1'b0, 32'h0, 4'hF, 3'b000);
        tick; tick;
        #1;
        total++;
        if (!(out_psel && out_penable)) begin
            bad++; $display("FAIL reset_pre_access got psel=%b penable=%b exp 1 1", out_psel, out_penable);
        end
        reset = 1'b0;
        #1;
        total++;
        if ({out_psel, out_penable, out_pwrite, out_paddr, out_pwdata, out_pstrb, out_pprot,
             req_pready, req_pslverr, grant_o} !== '0) begin
            bad++; $display("FAIL reset_mid_access got psel=%b penable=%b grant=%b", out_psel, out_penable, grant_o);
        end
        m_last = N - 1;
        set_req(0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 3'b000);
        tick;
        reset = 1'b1;
        set_req(1, 1'b1, 32'h3000_0200, 1'b0, 32'h0, 4'hF, 3'b001);
        tick;
        #1;
        total++;
        if (grant_o !== 2'b10) begin
            bad++; $display("FAIL reset_first_grant got=%b exp=10", grant_o);
        end
        complete(1, 32'h1234_5678, 1'b0, c);
        total++;
        if (!c.ok || c.ready !== 2'b10 || c.rdata !== 32'h1234_5678) begin
            bad++; $display("FAIL reset_lone_req1 ok=%0d ready=%b rdata=%h exp ready=10", c.ok, c.ready, c.rdata);
        end
        m_last = 1;
        req_psel = '0;
    endtask

    task automatic test_single_read;
        cap_t c;
        int   w;
        set_req(0, 1'b1, 32'h3000_0004, 1'b0, $urandom, 4'hF, 3'b000);
        w = rr_ref(2'b01, m_last);
        complete(5, 32'hDEAD_BEEF, 1'b0, c);
        total++;
        if (!c.ok || c.cycles != 2) begin
            bad++; $display("FAIL single_latency ok=%0d cycles=%0d exp=2", c.ok, c.cycles);
        end
        total++;
        if (c.addr !== 32'h3000_0004 || c.wr !== 1'b0) begin
            bad++; $display("FAIL single_addr got=%h wr=%b exp=30000004 wr=0", c.addr, c.wr);
        end
        total++;
        if (c.ready !== oh(w) || c.err !== 2'b00 || c.early) begin
            bad++; $display("FAIL single_ready got=%b err=%b early=%0d exp=%b", c.ready, c.err, c.early, oh(w));
        end
        total++;
        if (c.rdata !== 32'hDEAD_BEEF) begin
            bad++; $display("FAIL single_rdata got=%h exp=deadbeef", c.rdata);
        end
        m_last = w;
        req_psel = '0;
        #1;
        total++;
        if (out_psel !== 1'b0 || grant_o !== '0 || req_pready !== '0) begin
            bad++; $display("FAIL single_idle got psel=%b grant=%b pready=%b exp 0", out_psel, grant_o, req_pready);
        end
    endtask

    task automatic test_error;
        cap_t c;
        int   w;
        set_req(1, 1'b1, 32'h1000_1018, 1'b1, 32'h1, 4'hF, 3'b010);
        w = rr_ref(2'b10, m_last);
        complete(2, $urandom, 1'b1, c);
        total++;
        if (!c.ok || c.ready !== oh(w) || c.err !== oh(w)) begin
            bad++; $display("FAIL error_resp ok=%0d ready=%b err=%b exp=%b", c.ok, c.ready, c.err, oh(w));
        end
        total++;
        if (c.addr !== 32'h1000_1018 || c.wr !== 1'b1 || c.wd !== 32'h1 || c.strb !== 4'hF || c.prot !== 3'b010) begin
            bad++; $display("FAIL error_fields got addr=%h wr=%b wd=%h strb=%h prot=%h", c.addr, c.wr, c.wd, c.strb, c.prot);
        end
        m_last = w;
        req_psel = '0;
    endtask

    task automatic test_contention;
        cap_t c;
        int   w1, w2;
        rand_req(0, 1'b1);
        rand_req(1, 1'b1);
        w1 = rr_ref(2'b11, m_last);
        complete(1, 32'hAAAA_0000, 1'b0, c);
        total++;
        if (!c.ok || c.grant !== oh(w1) || c.addr !== f_addr[w1] || c.ready !== oh(w1)) begin
            bad++; $display("FAIL contend_first grant=%b addr=%h exp grant=%b addr=%h", c.grant, c.addr, oh(w1), f_addr[w1]);
        end
        m_last = w1;
        req_psel[w1] = 1'b0;
        #1;
        total++;
        if (out_psel !== 1'b0) begin
            bad++; $display("FAIL contend_gap got psel=%b exp=0", out_psel);
        end
        w2 = rr_ref(req_psel, m_last);
        complete(0, 32'hBBBB_0000, 1'b0, c);
        total++;
        if (!c.ok || c.cycles != 2 || c.grant !== oh(w2) || c.addr !== f_addr[w2]) begin
            bad++; $display("FAIL contend_second cycles=%0d grant=%b addr=%h exp 2 %b %h", c.cycles, c.grant, c.addr, oh(w2), f_addr[w2]);
        end
        m_last = w2;
        req_psel = '0;
    endtask

    task automatic test_fairness;
        cap_t         c;
        int           w;
        logic [N-1:0] prev;
        prev = '0;
        rand_req(0, 1'b1);
        rand_req(1, 1'b1);
        for (int t = 0; t < 8; t++) begin
            logic [31:0] rd;
            rd = $urandom;
            w = rr_ref(2'b11, m_last);
            complete($urandom_range(0, 2), rd, 1'b0, c);
            total++;
            if (!c.ok || c.cycles != 2 || c.grant !== oh(w) || c.addr !== f_addr[w] || c.rdata !== rd) begin
                bad++; $display("FAIL fair_xfer%0d cycles=%0d grant=%b addr=%h exp grant=%b addr=%h", t, c.cycles, c.grant, c.addr, oh(w), f_addr[w]);
            end
            total++;
            if (c.grant === prev) begin
                bad++; $display("FAIL fair_repeat%0d got=%b prev=%b", t, c.grant, prev);
            end
            prev = c.grant;
            m_last = w;
            if (t == 7) req_psel = '0;
            else rand_req(w, 1'b1);
            #1;
            total++;
            if (out_psel !== 1'b0) begin
                bad++; $display("FAIL fair_gap%0d got psel=%b exp=0", t, out_psel);
            end
        end
    endtask

    task automatic test_stability;
        cap_t        c;
        logic [31:0] a, d;
        int          w;
        a = $urandom; d = $urandom;
        set_req(0, 1'b1, a, 1'b1, d, 4'h3, 3'b101);
        w = rr_ref(2'b01, m_last);
        tick;
        #1;
        total++;
        if (out_psel !== 1'b1 || out_penable !== 1'b0 || out_paddr !== a) begin
            bad++; $display("FAIL stab_setup psel=%b penable=%b addr=%h exp 1 0 %h", out_psel, out_penable, out_paddr, a);
        end
        set_req(0, 1'b0, ~a, 1'b0, ~d, 4'hC, 3'b010);
        complete(3, $urandom, 1'b0, c);
        total++;
        if (!c.ok || c.addr !== a || c.wd !== d || c.wr !== 1'b1 || c.strb !== 4'h3 || c.ready !== oh(w)) begin
            bad++; $display("FAIL stab_hold addr=%h wd=%h ready=%b exp %h %h %b", c.addr, c.wd, c.ready, a, d, oh(w));
        end
        m_last = w;
        req_psel = '0;
    endtask

    task automatic test_random;
        cap_t         c;
        logic [N-1:0] mask;
        int           w, waits;
        logic         err;
        logic [31:0]  rd;
        for (int it = 0; it < 40; it++) begin
            mask = N'($urandom_range(1, (1 << N) - 1));
            for (int i = 0; i < N; i++) rand_req(i, mask[i]);
            w = rr_ref(mask, m_last);
            waits = $urandom_range(0, 4);
            err = 1'($urandom_range(0, 1));
            rd = $urandom;
            complete(waits, rd, err, c);
            total++;
            if (!c.ok || c.cycles != 2 || c.early || c.grant !== oh(w)) begin
                bad++; $display("FAIL rand%0d_ctrl ok=%0d cycles=%0d early=%0d grant=%b exp grant=%b", it, c.ok, c.cycles, c.early, c.grant, oh(w));
            end
            total++;
            if (c.addr !== f_addr[w] || c.wr !== f_wr[w] || c.wd !== f_wd[w] || c.strb !== f_strb[w] || c.prot !== f_prot[w]) begin
                bad++; $display("FAIL rand%0d_fields addr=%h wd=%h exp addr=%h wd=%h", it, c.addr, c.wd, f_addr[w], f_wd[w]);
            end
            total++;
            if (c.ready !== oh(w) || c.err !== (err ? oh(w) : '0) || c.rdata !== rd) begin
                bad++; $display("FAIL rand%0d_resp ready=%b err=%b rdata=%h exp %b %b %h", it, c.ready, c.err, c.rdata, oh(w), err ? oh(w) : '0, rd);
            end
            m_last = w;
            req_psel = '0;
            #1;
            total++;
            if (out_psel !== 1'b0 || grant_o !== '0) begin
                bad++; $display("FAIL rand%0d_idle psel=%b grant=%b exp 0", it, out_psel, grant_o);
            end
        end
    endtask

    initial begin
        req_paddr = '0; req_pwdata = '0; req_psel = '0; req_penable = '0; req_pwrite = '0;
        req_pstrb = '0; req_pprot = '0;
        out_pready = 1'b0; out_pslverr = 1'b0; out_prdata = '0;
        m_last = N - 1;
        test_reset;
        test_single_read;
        test_error;
        test_contention;
        test_fairness;
        test_stability;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
